// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection, transmitter FSM states and the
// baud divisor helper (also used by the receiver).
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_e;

   // Clocks per bit, rounded to the nearest integer.
   function automatic int baud_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers and registered full/empty flags.
// Read data is the current head word (fall-through), so a pop consumes the
// word that is visible on rd_data_o in the same cycle.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      used_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push, pop;

   // A full FIFO refuses writes even when a read frees a slot this cycle.
   assign push = wr_en_i && !full_q;
   assign pop  = rd_en_i && !empty_q;

   // Next pointers and the flags they imply.
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      used_d   = wr_ptr_d - rd_ptr_d;
      full_d   = (used_d == FULL_LVL);
      empty_d  = (used_d == '0);
   end

   // Pointer and flag registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array; contents need no reset since the pointers gate access.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign full_o    = full_q;
   assign empty_o   = empty_q;
   assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_tx_param.sv
// Buffered, parametrised UART transmitter. Words queue in a FIFO and are sent
// back-to-back; the line register lags the FSM by one clock so every bit,
// including the first start bit, is exactly BAUD_DIV clocks wide on the pin.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 27000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [DATA_BITS-1:0]          s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic                          tx_enable,
   output logic                          uart_tx,
   output logic                          busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int             BAUD_DIV  = baud_div(CLK_HZ, BAUD);
   localparam int             BCW       = $clog2(BAUD_DIV);
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
   localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
   localparam bit             HAS_PAR   = (PARITY != int'(PAR_NONE));
   localparam bit             EVEN_PAR  = (PARITY == int'(PAR_EVEN));

   if (BAUD_DIV < 4) begin : g_chk_baud
      $error("uart_tx_param: BAUD_DIV must be at least 4");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
      $error("uart_tx_param: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_chk_par
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("uart_tx_param: FIFO_DEPTH must be a power of two, at least 2");
   end

   tx_state_e            state_q, state_d;
   logic [BCW-1:0]       baud_cnt_q, baud_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 uart_tx_q;
   logic                 stop_end_q;
   logic                 tx_done_q;

   logic                 baud_end;
   logic                 can_start;
   logic                 load;
   logic                 frame_end;
   logic                 line_d;
   logic [DATA_BITS-1:0] fifo_rd_data;
   logic                 fifo_full;
   logic                 fifo_empty;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .wr_en_i   (s_valid),
      .wr_data_i (s_data),
      .rd_en_i   (load),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   assign baud_end  = (baud_cnt_q == BAUD_LAST);
   assign can_start = !fifo_empty && tx_enable;

   // Next-state, bit timing, shift/parity loading and the line value.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_end ? '0 : baud_cnt_q + BCW'(1);
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      load       = 1'b0;
      frame_end  = 1'b0;
      line_d     = 1'b1;
      case (state_q)
         S_IDLE: begin
            baud_cnt_d = '0;
            load       = can_start;
         end
         S_START: begin
            line_d = 1'b0;
            if (baud_end) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            line_d = shift_q[0];
            if (baud_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = HAS_PAR ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            line_d = parity_q;
            if (baud_end) begin
               state_d   = S_STOP;
               bit_cnt_d = '0;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               if (bit_cnt_q == STOP_LAST) begin
                  frame_end = 1'b1;
                  state_d   = S_IDLE;
                  load      = can_start;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Popping the head word starts a new frame, from IDLE or straight
      // out of the last stop bit.
      if (load) begin
         state_d    = S_START;
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
         shift_d    = fifo_rd_data;
         parity_d   = EVEN_PAR ? ^fifo_rd_data : ~^fifo_rd_data;
      end
   end

   // State, counters, line register and the end-of-frame pulse pipeline.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         uart_tx_q  <= 1'b1;
         stop_end_q <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         uart_tx_q  <= line_d;
         stop_end_q <= frame_end;
         tx_done_q  <= stop_end_q;
      end
   end

   assign uart_tx = uart_tx_q;
   assign tx_done = tx_done_q;
   assign s_ready = !fifo_full;
   // The last stop bit is still on the pin for one clock after the FSM leaves it.
   assign busy    = (state_q != S_IDLE) || !fifo_empty || stop_end_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances (default 8N1 at 234
// clocks/bit, 7E2, 7O2 and a fast 8N1 at 10 clocks/bit) share clock/reset.
`timescale 1ns/1ps
module tb_uart_tx_param;

   logic            clk = 1'b0;
   logic            resetn;
   logic [8:0]      din;
   logic [3:0]      vld;
   logic [3:0]      ten;
   logic [3:0]      rdy_w;
   logic [3:0]      line_w;
   logic [3:0]      busy_w;
   logic [3:0]      done_w;
   logic [3:0][4:0] lvl_w;

   int n_tests = 0;
   int n_fail  = 0;
   int sel     = 0;

   logic [15:0] rx_frames [16];
   logic [4:0]  rx_lvl    [16];
   int          rx_wait;
   int          rx_done_cnt;
   int          rx_last_done;

   always #5 clk = ~clk;

   uart_tx_param u_def (
      .clk(clk), .resetn(resetn), .s_data(din[7:0]), .s_valid(vld[0]), .s_ready(rdy_w[0]),
      .tx_enable(ten[0]), .uart_tx(line_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]),
      .fifo_level(lvl_w[0]));

   uart_tx_param #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_even (
      .clk(clk), .resetn(resetn), .s_data(din[6:0]), .s_valid(vld[1]), .s_ready(rdy_w[1]),
      .tx_enable(ten[1]), .uart_tx(line_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]),
      .fifo_level(lvl_w[1]));

   uart_tx_param #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_odd (
      .clk(clk), .resetn(resetn), .s_data(din[6:0]), .s_valid(vld[2]), .s_ready(rdy_w[2]),
      .tx_enable(ten[2]), .uart_tx(line_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]),
      .fifo_level(lvl_w[2]));

   uart_tx_param #(.CLK_HZ(1000), .BAUD(100)) u_fast (
      .clk(clk), .resetn(resetn), .s_data(din[7:0]), .s_valid(vld[3]), .s_ready(rdy_w[3]),
      .tx_enable(ten[3]), .uart_tx(line_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]),
      .fifo_level(lvl_w[3]));

   function automatic logic mux_line();
      return line_w[sel];
   endfunction
   function automatic logic mux_done();
      return done_w[sel];
   endfunction
   function automatic logic [4:0] mux_lvl();
      return lvl_w[sel];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Drive one word into the selected instance; returns 1 time unit after the push edge.
   task automatic push(input logic [8:0] d);
      @(negedge clk);
      din      = d;
      vld[sel] = 1'b1;
      @(posedge clk);
      #1;
      vld[sel] = 1'b0;
   endtask

   // Wait for a start bit, then sample the middle of every bit of nframes
   // contiguous frames; record tx_done pulses relative to the start edge.
   task automatic rx_stream(input int div, input int nbits, input int nframes);
      int  flen;
      int  pos;
      int  f;
      int  k;
      bit  found;
      flen         = div * nbits;
      rx_wait      = 0;
      rx_done_cnt  = 0;
      rx_last_done = -1;
      for (int i = 0; i < 16; i++) begin
         rx_frames[i] = '0;
         rx_lvl[i]    = '0;
      end
      found = 1'b0;
      for (int c = 0; c < 20000 && !found; c++) begin
         @(posedge clk);
         #1;
         rx_wait++;
         if (mux_line() == 1'b0) found = 1'b1;
      end
      if (!found) begin
         check("rx_start_timeout", 32'd0, 32'd1);
         return;
      end
      for (int t = 0; t < nframes * flen + 4 * div; t++) begin
         if (t > 0) begin
            @(posedge clk);
            #1;
         end
         if (mux_done()) begin
            rx_done_cnt++;
            rx_last_done = t;
         end
         if (t < nframes * flen) begin
            pos = t % flen;
            f   = t / flen;
            if (pos % div == div / 2) begin
               k = pos / div;
               rx_frames[f][k] = mux_line();
               if (k == 0) rx_lvl[f] = mux_lvl();
            end
         end
      end
   endtask

   initial begin
      int          c;
      int          low_cnt;
      logic [7:0]  w;
      logic [15:0] exp_frame;

      resetn = 1'b0;
      din    = '0;
      vld    = '0;
      ten    = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_line",  32'(line_w), 32'hF);
      check("rst_done",  32'(done_w), 32'h0);
      check("rst_busy",  32'(busy_w), 32'h0);
      check("rst_ready", 32'(rdy_w),  32'hF);
      check("rst_level", 32'(lvl_w[0]), 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Default 8N1: 0x55, start bit two edges after the push, 2340-clock frame.
      sel = 0;
      push(9'h055);
      rx_stream(234, 10, 1);
      check("def_latency",  32'(rx_wait), 32'd2);
      check("def_frame",    32'(rx_frames[0]), 32'h02AA);
      check("def_done_cnt", 32'(rx_done_cnt), 32'd1);
      check("def_done_at",  32'(rx_last_done), 32'd2340);
      check("def_busy_end", 32'(busy_w[0]), 32'd0);

      // 7E2 and 7O2 with 0x03: parity 0 then 1, 11 bits of 10 clocks.
      sel = 1;
      push(9'h003);
      rx_stream(10, 11, 1);
      check("even_frame",   32'(rx_frames[0]), 32'h0606);
      check("even_done_at", 32'(rx_last_done), 32'd110);
      check("even_latency", 32'(rx_wait), 32'd2);
      sel = 2;
      push(9'h003);
      rx_stream(10, 11, 1);
      check("odd_frame",    32'(rx_frames[0]), 32'h0706);
      check("odd_done_at",  32'(rx_last_done), 32'd110);

      // Fill the FIFO with transmission held off; the 17th word must bounce.
      sel    = 3;
      ten[3] = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         w      = 8'h30 + 8'(i * 13);
         din    = (i < 16) ? {1'b0, w} : 9'h0EE;
         vld[3] = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("fill_level_%0d", i), 32'(lvl_w[3]), (i < 16) ? i + 1 : 16);
         if (i == 14) check("ready_before_full", 32'(rdy_w[3]), 32'd1);
         if (i == 15) check("ready_after_full", 32'(rdy_w[3]), 32'd0);
      end
      vld[3] = 1'b0;
      @(negedge clk);
      ten[3] = 1'b1;
      rx_stream(10, 10, 16);
      for (int i = 0; i < 16; i++) begin
         w         = 8'h30 + 8'(i * 13);
         exp_frame = {6'b0, 1'b1, w, 1'b0};
         check($sformatf("burst_frame_%0d", i), 32'(rx_frames[i]), 32'(exp_frame));
         check($sformatf("burst_level_%0d", i), 32'(rx_lvl[i]), 32'(15 - i));
      end
      check("burst_done_cnt", 32'(rx_done_cnt), 32'd16);
      check("burst_done_at",  32'(rx_last_done), 32'd1600);
      check("burst_level_end", 32'(lvl_w[3]), 32'd0);
      check("burst_busy_end",  32'(busy_w[3]), 32'd0);

      // tx_enable dropped mid-frame with three words queued.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         din    = {1'b0, 8'h61 + 8'(i)};
         vld[3] = 1'b1;
         @(posedge clk);
         #1;
      end
      vld[3] = 1'b0;
      check("hold_level_q", 32'(lvl_w[3]), 32'd3);
      c = 0;
      for (int i = 1; i <= 200 && c == 0; i++) begin
         @(posedge clk);
         #1;
         if (i == 20) ten[3] = 1'b0;
         if (done_w[3]) c = i;
      end
      check("hold_frame_done", 32'(c), 32'd99);
      low_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (!line_w[3]) low_cnt++;
      end
      check("hold_line_idle", 32'(low_cnt), 32'd0);
      check("hold_level",     32'(lvl_w[3]), 32'd3);
      check("hold_busy",      32'(busy_w[3]), 32'd1);
      ten[3] = 1'b1;
      rx_stream(10, 10, 3);
      for (int i = 0; i < 3; i++) begin
         exp_frame = {6'b0, 1'b1, 8'h62 + 8'(i), 1'b0};
         check($sformatf("resume_frame_%0d", i), 32'(rx_frames[i]), 32'(exp_frame));
      end
      check("resume_done_cnt", 32'(rx_done_cnt), 32'd3);

      // Simultaneous push and pop at level 5.
      ten[3] = 1'b0;
      for (int i = 0; i < 5; i++) push({1'b0, 8'h81 + 8'(i)});
      check("pp_level_before", 32'(lvl_w[3]), 32'd5);
      @(negedge clk);
      din    = 9'h086;
      vld[3] = 1'b1;
      ten[3] = 1'b1;
      @(posedge clk);
      #1;
      vld[3] = 1'b0;
      check("pp_level_after", 32'(lvl_w[3]), 32'd5);
      rx_stream(10, 10, 6);
      for (int i = 0; i < 6; i++) begin
         exp_frame = {6'b0, 1'b1, 8'h81 + 8'(i), 1'b0};
         check($sformatf("pp_frame_%0d", i), 32'(rx_frames[i]), 32'(exp_frame));
      end

      // Asynchronous reset while a data bit is low on the line.
      push(9'h03C);
      push(9'h011);
      push(9'h022);
      repeat (25) @(posedge clk);
      #1;
      check("rst_mid_pre_line", 32'(line_w[3]), 32'd0);
      #2;
      resetn = 1'b0;
      #1;
      check("rst_mid_line",  32'(line_w[3]), 32'd1);
      check("rst_mid_level", 32'(lvl_w[3]), 32'd0);
      check("rst_mid_ready", 32'(rdy_w[3]), 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      push(9'h0A5);
      rx_stream(10, 10, 1);
      check("post_rst_latency", 32'(rx_wait), 32'd2);
      check("post_rst_frame",   32'(rx_frames[0]), 32'h034A);
      check("post_rst_done",    32'(rx_done_cnt), 32'd1);
      check("post_rst_level",   32'(lvl_w[3]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
